// File: rtl/proc_io_pkg.sv
// Shared constants and helpers for the processor I/O scheduler.
// Imported by io_fifo and proc_io_ctrl.
package proc_io_pkg;

  localparam int DEF_NUBITS = 32;
  localparam int DEF_FDEPTH = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int CNT_W     = clog2(DEF_FDEPTH) + 1;
  localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with a combinational head word. The caller owns all
// overflow/underflow policy and never pops an empty FIFO.
module io_fifo
  import proc_io_pkg::*;
#(
  parameter int WIDTH = DEF_NUBITS,
  parameter int DEPTH = DEF_FDEPTH,
  localparam int AW   = clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wrPtr_d = wrPtr_q + AW'(push_i);
    rdPtr_d = rdPtr_q + AW'(pop_i);
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !rst_i) mem_q[wrPtr_q] <= data_i;
  end

  assign head_o  = mem_q[rdPtr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/proc_io_ctrl.sv
// I/O scheduler between word streams and the processor's multiplexed I/O bus.
// Define PROC_IO_ERR_CNT_EN to build the saturating error event counter.
module proc_io_ctrl
  import proc_io_pkg::*;
#(
  parameter int NUBITS = DEF_NUBITS,
  parameter int NUIOIN = 2,
  parameter int NUIOOU = 2,
  parameter int FDEPTH = DEF_FDEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUIOIN*NUBITS-1:0] s_data_i,
  input  logic [NUIOIN-1:0]        s_valid_i,
  output logic [NUIOIN-1:0]        s_ready_o,
  output logic [NUBITS-1:0]        io_in_o,
  input  logic [NUIOIN-1:0]        req_in_i,
  input  logic [NUBITS-1:0]        io_out_i,
  input  logic [NUIOOU-1:0]        out_en_i,
  output logic [NUIOOU*NUBITS-1:0] m_data_o,
  output logic [NUIOOU-1:0]        m_valid_o,
  input  logic [NUIOOU-1:0]        m_ready_i,
  output logic [NUIOIN-1:0]        underflow_o,
  output logic [NUIOOU-1:0]        overflow_o,
  input  logic                     clr_err_i,
  output logic [ERR_CNT_W-1:0]     err_cnt_o
);

  localparam int FCW = clog2(FDEPTH) + 1;

  logic [NUIOIN-1:0] inSel, inPush, inPop, inEmpty, inFull, underflowEvt;
  logic [FCW-1:0]    inCount [NUIOIN];
  logic [NUBITS-1:0] inHead  [NUIOIN];

  logic [NUIOOU-1:0] outSel, outPush, outPop, outEmpty, outFull, overflowEvt;
  logic [FCW-1:0]    outCount [NUIOOU];
  logic [NUBITS-1:0] outHead  [NUIOOU];

  logic [NUIOIN-1:0] underflow_q, underflow_d;
  logic [NUIOOU-1:0] overflow_q, overflow_d;

  // Isolate the lowest set strobe so only one port is ever serviced.
  assign inSel  = req_in_i & (~req_in_i + NUIOIN'(1));
  assign outSel = out_en_i & (~out_en_i + NUIOOU'(1));

  for (genvar k = 0; k < NUIOIN; k++) begin : gIn
    logic unusedFull;
    assign unusedFull      = inFull[k];
    assign s_ready_o[k]    = ~rst_i & (inCount[k] != FCW'(FDEPTH));
    assign inPush[k]       = s_valid_i[k] & s_ready_o[k];
    assign inPop[k]        = inSel[k] & ~inEmpty[k];
    assign underflowEvt[k] = inSel[k] & inEmpty[k];

    io_fifo #(.WIDTH(NUBITS), .DEPTH(FDEPTH)) uInFifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (inPush[k]),
      .pop_i   (inPop[k]),
      .data_i  (s_data_i[k*NUBITS +: NUBITS]),
      .head_o  (inHead[k]),
      .full_o  (inFull[k]),
      .empty_o (inEmpty[k]),
      .count_o (inCount[k])
    );
  end

  // A full output FIFO still accepts a write when the consumer drains it.
  for (genvar k = 0; k < NUIOOU; k++) begin : gOut
    logic unusedCount;
    assign unusedCount    = ^outCount[k];
    assign m_valid_o[k]   = ~rst_i & ~outEmpty[k];
    assign outPop[k]      = m_valid_o[k] & m_ready_i[k];
    assign outPush[k]     = outSel[k] & (~outFull[k] | outPop[k]);
    assign overflowEvt[k] = outSel[k] & outFull[k] & ~outPop[k];
    assign m_data_o[k*NUBITS +: NUBITS] = outHead[k];

    io_fifo #(.WIDTH(NUBITS), .DEPTH(FDEPTH)) uOutFifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (outPush[k]),
      .pop_i   (outPop[k]),
      .data_i  (io_out_i),
      .head_o  (outHead[k]),
      .full_o  (outFull[k]),
      .empty_o (outEmpty[k]),
      .count_o (outCount[k])
    );
  end

  always_comb begin
    io_in_o = '0;
    for (int k = 0; k < NUIOIN; k++) begin
      if (inSel[k] && !inEmpty[k] && !rst_i) io_in_o = inHead[k];
    end
  end

  // A fresh error in the clearing cycle keeps its flag set.
  always_comb begin
    underflow_d = underflow_q | underflowEvt;
    overflow_d  = overflow_q | overflowEvt;
    if (clr_err_i) begin
      underflow_d = underflowEvt;
      overflow_d  = overflowEvt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      underflow_q <= '0;
      overflow_q  <= '0;
    end else begin
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

  assign underflow_o = underflow_q;
  assign overflow_o  = overflow_q;

`ifdef PROC_IO_ERR_CNT_EN
  localparam int SUM_W = ERR_CNT_W + 1;

  logic [ERR_CNT_W-1:0] errCnt_q, errCnt_d;
  logic [1:0]           errEvents;
  logic [SUM_W-1:0]     errBase, errSum;

  // At most one port of each direction errs per cycle, so events are 0..2.
  always_comb begin
    errEvents = {1'b0, |underflowEvt} + {1'b0, |overflowEvt};
    errBase   = clr_err_i ? '0 : {1'b0, errCnt_q};
    errSum    = errBase + SUM_W'(errEvents);
    errCnt_d  = errSum[ERR_CNT_W] ? '1 : errSum[ERR_CNT_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) errCnt_q <= '0;
    else       errCnt_q <= errCnt_d;
  end

  assign err_cnt_o = errCnt_q;
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: doc/proc_io_ctrl.md
Name: proc_io_ctrl

Overview:
- I/O scheduler between external word streams and the fixed-point processor's multiplexed I/O bus (io_in/io_out, one-hot req_in/out_en from the address decoders).
- Buffers each input port in its own FIFO and presents the selected head word on io_in when the processor requests it.
- Captures io_out into a per-port output FIFO on out_en and drains it to consumers over valid/ready.
- Detects and flags processor reads from an empty port and writes to a full port.

Parameters:
- NUBITS, 32, data word width.
- NUIOIN, 2, number of processor input ports.
- NUIOOU, 2, number of processor output ports.
- FDEPTH, 4, entries per FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_data  in  NUIOIN*NUBITS  producer words; port k occupies bits [k*NUBITS +: NUBITS].
- s_valid  in  NUIOIN  producer valid per port.
- s_ready  out  NUIOIN  FIFO k not full.
- io_in  out  NUBITS  word to processor.
- req_in  in  NUIOIN  processor read strobe, one-hot.
- io_out  in  NUBITS  word from processor.
- out_en  in  NUIOOU  processor write strobe, one-hot.
- m_data  out  NUIOOU*NUBITS  consumer words, same packing as s_data.
- m_valid  out  NUIOOU  output FIFO k not empty.
- m_ready  in  NUIOOU  consumer ready per port.
- underflow  out  NUIOIN  sticky: read while FIFO empty.
- overflow  out  NUIOOU  sticky: write while FIFO full.
- clr_err  in  1  clears sticky flags and counter.
- err_cnt  out  16  error event counter; see Optional Feature.

Behaviour:
- Reset (synchronous, while rst=1): all pointers, counts, flags and err_cnt go to 0.
  - s_ready=0, m_valid=0, io_in=0 while rst=1.
  - Any push or pop presented during reset is ignored.
- Input FIFO k:
  - Push on the clock edge where s_valid[k] & s_ready[k].
  - s_ready[k] = (count_k != FDEPTH), decoded from registered count only; no bypass.
- Processor read:
  - Selected port = lowest index set in req_in. Only the selected port is popped.
  - io_in is combinational: head word of the selected port; 0 if none selected or the selected FIFO is empty.
  - Pop occurs at the same edge.
  - Empty read: no pop, underflow[k] set at the edge.
  - Push and pop in the same cycle on a non-full, non-empty FIFO: count unchanged.
  - Push to an empty FIFO with a simultaneous read: counts as an underflow; the pushed word is retained.
- Latency:
  - Word accepted at edge t is readable by the processor from cycle t+1.
  - Word written via out_en at edge t gives m_valid=1 in cycle t+1.
- Output FIFO k:
  - m_valid[k] = count_k != 0; m_data slice k = head word.
  - Pop on m_valid[k] & m_ready[k].
  - Push io_out on out_en[k]; lowest index wins if out_en is not one-hot.
  - Full with a simultaneous pop: the push succeeds and count is unchanged.
  - Full with no pop: the word is dropped and overflow[k] is set.
- Pointers wrap modulo FDEPTH. Counts are $clog2(FDEPTH)+1 bits and never exceed FDEPTH.
- clr_err: underflow, overflow and err_cnt clear at the next edge. A new error in the same cycle wins (flag set; counter goes to 1).
- No state machine beyond FIFO occupancy; the processor has no stall input, so errors are flagged, never back-pressured.

Optional Feature:
- Macro: PROC_IO_ERR_CNT_EN.
- Defined: err_cnt increments by the number of error events per cycle (underflow plus overflow events, at most 2) and saturates at 16'hFFFF.
- Undefined: err_cnt tied to 0 and no counter logic is generated. Sticky flags behave identically in both builds.

Decomposition:
- Shared package proc_io_pkg holds:
  - default NUBITS and FDEPTH;
  - the function clog2;
  - the localparam CNT_W = clog2(FDEPTH)+1;
  - ERR_CNT_W = 16.
- One sub-module: io_fifo.
  - Synchronous FIFO with push/pop/full/empty/count and combinational head.
  - Instantiated NUIOIN + NUIOOU times via generate.
  - Input and output overflow/underflow policies live in proc_io_ctrl, not in io_fifo.

Test Plan:
- Reset, then push 0x11111111, 0x22222222 on port 0; pulse req_in=2'b01 twice from cycle t+1 -> io_in = 0x11111111 then 0x22222222; s_ready[0] stays 1; underflow=0.
- Fill port 1 with 4 words with no reads -> s_ready[1]=0 after the 4th edge; a 5th s_valid is not accepted; a read restores s_ready[1]=1 next cycle.
- req_in=2'b10 with port 1 empty -> io_in=0 and underflow[1]=1. clr_err pulsed together with a new empty read -> flag stays 1. clr_err alone -> flag clears.
- out_en=2'b01 with io_out=0xDEADBEEF and m_ready=0 -> m_valid[0]=1 next cycle, m_data[31:0]=0xDEADBEEF. 4 more writes -> 5th dropped, overflow[0]=1; write while full with m_ready=1 -> accepted, no flag.
- Assert rst mid-stream with both FIFOs half full -> all counts 0, m_valid=0, s_ready=0 during reset, s_ready=2'b11 after release; prior data is not readable.
- With PROC_IO_ERR_CNT_EN, one underflow and one overflow in the same cycle -> err_cnt +2; preload near 16'hFFFF -> saturates. Without the macro -> err_cnt=0.
